// File: rtl/ball_pkg.sv
// Shared playfield defaults, FSM state encoding and the per-axis bounce step.
package ball_pkg;

    localparam int unsigned X_MAX_DEF = 160;
    localparam int unsigned Y_MAX_DEF = 120;
    localparam int unsigned SIZE_DEF  = 4;
    localparam int unsigned POS_W     = 10;
    localparam int unsigned COL_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ERASE  = 2'd1,
        S_UPDATE = 2'd2,
        S_DRAW   = 2'd3
    } state_e;

    // One step along an axis; returns {new_dir, new_pos}. The wall rule overrides a flipped direction.
    function automatic logic [POS_W:0] axis_step(
        input logic [POS_W-1:0] pos,
        input logic             dir,
        input logic             flip,
        input logic [POS_W-1:0] lim
    );
        logic d;
        d = dir ^ flip;
        if (d && (pos == lim)) begin
            return {1'b0, pos - POS_W'(1)};
        end
        if (!d && (pos == '0)) begin
            return {1'b1, pos + POS_W'(1)};
        end
        return d ? {1'b1, pos + POS_W'(1)} : {1'b0, pos - POS_W'(1)};
    endfunction

endpackage

// File: rtl/ball_ctrl_square_sweep.sv
// Row-major SIZE x SIZE offset counter; steps only when the current pixel is accepted.
module square_sweep
    import ball_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             advance,
    output logic [POS_W-1:0] cx,
    output logic [POS_W-1:0] cy,
    output logic             done
);

    localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [CNT_W-1:0] r_cx;
    logic [CNT_W-1:0] r_cy;
    logic             w_last_cx;
    logic             w_last_cy;

    assign w_last_cx = (r_cx == CNT_W'(SIZE - 1));
    assign w_last_cy = (r_cy == CNT_W'(SIZE - 1));

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (advance) begin
            if (w_last_cx) begin
                r_cx <= '0;
                r_cy <= w_last_cy ? '0 : r_cy + CNT_W'(1);
            end else begin
                r_cx <= r_cx + CNT_W'(1);
            end
        end
    end

    assign cx   = POS_W'(r_cx);
    assign cy   = POS_W'(r_cy);
    assign done = advance && w_last_cx && w_last_cy;

endmodule

// File: rtl/ball_ctrl.sv
// Bouncing-ball controller: erase old square, step position with wall/brick bounces, draw new square.
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned       X_MAX       = X_MAX_DEF,
    parameter int unsigned       Y_MAX       = Y_MAX_DEF,
    parameter int unsigned       SIZE        = SIZE_DEF,
    parameter logic [COL_W-1:0]  BALL_COLOUR = 3'b111
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             hit_x,
    input  logic             hit_y,
    input  logic             plot_ready,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic [POS_W-1:0] plot_x,
    output logic [POS_W-1:0] plot_y,
    output logic [COL_W-1:0] plot_colour,
    output logic             plot,
    output logic             busy
);

    localparam logic [POS_W-1:0] LIM_X = POS_W'(X_MAX - SIZE);
    localparam logic [POS_W-1:0] LIM_Y = POS_W'(Y_MAX - SIZE);
    localparam logic [POS_W-1:0] X_RST = POS_W'((X_MAX - SIZE) / 2);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_MAX - SIZE - 1);

    state_e           r_state;
    state_e           w_next;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic             r_x_dir;
    logic             r_y_dir;
    logic             r_hit_x;
    logic             r_hit_y;
    logic             w_go;
    logic             w_xfer;
    logic             w_sweep_start;
    logic             w_sweep_done;
    logic [POS_W-1:0] w_cx;
    logic [POS_W-1:0] w_cy;

    assign w_go          = frame_tick && enable;
    assign w_xfer        = plot && plot_ready;
    assign w_sweep_start = (r_state == S_IDLE) || (r_state == S_UPDATE);

    square_sweep #(.SIZE(SIZE)) u_sweep (
        .clk     (clk),
        .resetn  (resetn),
        .start   (w_sweep_start),
        .advance (w_xfer),
        .cx      (w_cx),
        .cy      (w_cy),
        .done    (w_sweep_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_go)         w_next = S_ERASE;
            S_ERASE:  if (w_sweep_done) w_next = S_UPDATE;
            S_UPDATE:                   w_next = S_DRAW;
            S_DRAW:   if (w_sweep_done) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        plot        = 1'b0;
        busy        = 1'b1;
        plot_colour = '0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_ERASE: plot = 1'b1;
            S_DRAW: begin
                plot        = 1'b1;
                plot_colour = BALL_COLOUR;
            end
            default: ;
        endcase
    end

    // Hit flags accumulate until UPDATE consumes them; a hit landing in UPDATE itself is kept for next move.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x     <= X_RST;
            r_y     <= Y_RST;
            r_x_dir <= 1'b1;
            r_y_dir <= 1'b0;
            r_hit_x <= 1'b0;
            r_hit_y <= 1'b0;
        end else begin
            r_hit_x <= ((r_state == S_UPDATE) ? 1'b0 : r_hit_x) | hit_x;
            r_hit_y <= ((r_state == S_UPDATE) ? 1'b0 : r_hit_y) | hit_y;
            if (r_state == S_UPDATE) begin
                {r_x_dir, r_x} <= axis_step(r_x, r_x_dir, r_hit_x, LIM_X);
                {r_y_dir, r_y} <= axis_step(r_y, r_y_dir, r_hit_y, LIM_Y);
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign plot_x = r_x + w_cx;
    assign plot_y = r_y + w_cy;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: vector table, long random-ready walk to both walls, corner sequences.
module tb_ball_ctrl;

    localparam int XM = 160;
    localparam int YM = 120;
    localparam int SZ = 4;
    localparam int BC = 7;

    logic       clk = 1'b0;
    logic       resetn, enable, frame_tick, hit_x, hit_y, plot_ready;
    logic [9:0] x, y, plot_x, plot_y;
    logic [2:0] plot_colour;
    logic       plot, busy;

    ball_ctrl dut (
        .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
        .hit_x(hit_x), .hit_y(hit_y), .plot_ready(plot_ready),
        .x(x), .y(y), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: position plus signed velocity, pending brick flips.
    int mx, my, vx, vy;
    bit phx, phy;

    typedef struct { int px; int py; int col; } pix_t;
    pix_t exp_q[$];

    function automatic void model_reset();
        mx = (XM - SZ) / 2; my = YM - SZ - 1; vx = 1; vy = -1; phx = 0; phy = 0;
    endfunction

    function automatic void model_update();
        int np;
        if (phx) vx = -vx;
        if (phy) vy = -vy;
        phx = 0; phy = 0;
        np = mx + vx;
        if (np < 0 || np > XM - SZ) begin vx = -vx; np = mx + vx; end
        mx = np;
        np = my + vy;
        if (np < 0 || np > YM - SZ) begin vy = -vy; np = my + vy; end
        my = np;
    endfunction

    function automatic void push_square(input int bx, input int by, input int col);
        pix_t p;
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++) begin
                p.px = bx + c; p.py = by + r; p.col = col;
                exp_q.push_back(p);
            end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic idle_hits(input bit hx, input bit hy);
        hit_x = hx; hit_y = hy;
        tick();
        hit_x = 1'b0; hit_y = 1'b0;
        phx |= hx; phy |= hy;
    endtask

    // One full move cycle, checking every transfer against the model's expected pixel stream.
    task automatic run_move(input bit rnd, input bit hit_draw, input bit dup_tick,
                            input bit rst_draw, input bit drop_en);
        int k, cyc, hx0, hy0;
        bit hold, injected;
        exp_q.delete();
        push_square(mx, my, 0);
        model_update();
        push_square(mx, my, BC);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("busy_after_tick", int'(busy), 1);
        k = 0; hold = 0; injected = 0; hx0 = 0; hy0 = 0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (k == 32 && !busy) break;
            plot_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            frame_tick = dup_tick && (cyc == 3);
            if (drop_en && cyc == 2) enable = 1'b0;
            hit_y = 1'b0;
            if (hold) begin
                chk("hold_x", int'(plot_x), hx0);
                chk("hold_y", int'(plot_y), hy0);
                hold = 0;
            end
            if (rst_draw && k == 20) begin
                plot_ready = 1'b1;
                chk("rst_plot_before", int'(plot), 1);
                resetn = 1'b0;
                tick();
                resetn = 1'b1;
                model_reset();
                chk("rst_plot_drop", int'(plot), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_x", int'(x), mx);
                chk("rst_y", int'(y), my);
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk("rst_no_plot", int'(plot), 0);
                end
                return;
            end
            if (hit_draw && !injected && k == 20) begin
                hit_y = 1'b1; injected = 1; phy = 1;
            end
            if (plot) begin
                if (plot_ready) begin
                    if (k < 32) begin
                        chk("pix_x", int'(plot_x), exp_q[k].px);
                        chk("pix_y", int'(plot_y), exp_q[k].py);
                        chk("pix_col", int'(plot_colour), exp_q[k].col);
                    end else begin
                        chk("extra_pixel", k, 31);
                    end
                    k++;
                end else begin
                    hold = 1; hx0 = int'(plot_x); hy0 = int'(plot_y);
                end
            end
            tick();
        end
        hit_y = 1'b0; frame_tick = 1'b0; enable = 1'b1; plot_ready = 1'b1;
        chk("transfers", k, 32);
        chk("busy_end", int'(busy), 0);
        chk("pos_x", int'(x), mx);
        chk("pos_y", int'(y), my);
        if (!rnd) chk("move_cycles", cyc + 1, 34);
        if (dup_tick)
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("no_requeue", int'(busy), 0);
            end
    endtask

    typedef struct { bit hx; bit hy; bit rnd; int ex; int ey; } vec_t;
    vec_t tbl[4];

    initial begin
        bit seen_x, seen_y, wx, wy;
        resetn = 1'b0; enable = 1'b1; frame_tick = 1'b0;
        hit_x = 1'b0; hit_y = 1'b0; plot_ready = 1'b1;
        tbl[0] = '{0, 0, 0, 79, 114};
        tbl[1] = '{1, 0, 1, 78, 113};
        tbl[2] = '{0, 0, 0, 77, 112};
        tbl[3] = '{0, 1, 1, 76, 113};

        do_reset();
        chk("reset_x", int'(x), 78);
        chk("reset_y", int'(y), 115);
        chk("reset_busy", int'(busy), 0);
        chk("reset_plot", int'(plot), 0);

        for (int i = 0; i < 4; i++) begin
            if (tbl[i].hx || tbl[i].hy) idle_hits(tbl[i].hx, tbl[i].hy);
            run_move(tbl[i].rnd, 0, 0, 0, 0);
            chk("tbl_x", int'(x), tbl[i].ex);
            chk("tbl_y", int'(y), tbl[i].ey);
        end

        // Walk with random back-pressure until both the right wall and the top wall have bounced.
        seen_x = 0; seen_y = 0;
        for (int m = 0; m < 400 && !(seen_x && seen_y); m++) begin
            wx = (mx == XM - SZ) && (vx == 1);
            wy = (my == 0) && (vy == -1);
            run_move(1, 0, 0, 0, 0);
            if (wx) begin chk("x_wall", int'(x), XM - SZ - 1); seen_x = 1; end
            if (wy) begin chk("y_wall", int'(y), 1); seen_y = 1; end
        end
        chk("walls_reached", int'(seen_x && seen_y), 1);

        run_move(0, 1, 1, 0, 0);
        run_move(0, 0, 0, 0, 0);
        chk("hit_y_dir", int'(y), my);

        enable = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("disabled_busy", int'(busy), 0);
        tick();
        chk("disabled_plot", int'(plot), 0);
        enable = 1'b1;

        run_move(0, 0, 0, 0, 1);
        tick();
        chk("enable_restored_idle", int'(busy), 0);

        for (int m = 0; m < 8; m++) begin
            idle_hits(1'($urandom_range(1)), 1'($urandom_range(1)));
            run_move(1, 0, 0, 0, 0);
        end

        run_move(0, 0, 0, 0, 0);
        run_move(0, 0, 0, 1, 0);
        run_move(0, 0, 0, 0, 0);
        chk("post_rst_x", int'(x), 79);
        chk("post_rst_y", int'(y), 114);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
